beep_func_arbiter: RTL and testbench
====================================

# beep_func_arbiter

Round-robin arbiter that shares the single beep function module (S/O pattern generator driven by a 2-bit one-hot start code and a one-cycle done pulse) between two independent command controllers. Examples are the FIFO-fed command controller and a key-scan controller. Each requester holds its start code until it receives its own done pulse. The arbiter latches the granted code, drives the function module, and routes the done pulse back to the owner. A watchdog aborts a run whose done never arrives.

## Interface
- TIMEOUT_CYCLES, 24'd12_000_000: max cycles in RUN before abort; 0 disables watchdog
- TO_W, 24: width of the watchdog counter; must hold TIMEOUT_CYCLES-1

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_a_start  in  2  requester A code: 2'b10 = S, 2'b01 = O, 2'b00 = idle, 2'b11 = invalid
- req_a_done  out  1  one-cycle pulse, A's request finished or aborted
- req_b_start  in  2  requester B code, same encoding as A
- req_b_done  out  1  one-cycle pulse, B's request finished or aborted
- func_start_sig  out  2  code to the function module, held for the whole run
- func_done_sig  in  1  one-cycle done pulse from the function module
- busy  out  1  high in RUN and RELEASE
- owner  out  1  0 = A, 1 = B; current or last grant
- err_sig  out  1  one-cycle pulse on timeout abort or invalid-code reject

## Operation
- Reset values:
  - all outputs 0 (owner = 0)
  - state IDLE
  - priority pointer favours A
  - watchdog counter 0
- A request is pending when its code is nonzero.
- IDLE:
  - one pending requester: grant it
  - both pending: grant the one the pointer favours
  - on grant: owner <= winner; pointer <= favour the loser; code latched into cmd; then:
    - code 2'b11: func_start_sig stays 00; done and err_sig pulse together on the next edge; go to RELEASE
    - otherwise: func_start_sig <= cmd; counter <= 0; go to RUN
- RUN:
  - func_start_sig holds cmd; requester code changes are ignored
  - func_done_sig high: func_start_sig <= 00; owner's done <= 1; go to RELEASE
  - else, counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: func_start_sig <= 00; owner's done <= 1; err_sig <= 1; go to RELEASE
  - else counter increments
- RELEASE (exactly one cycle): done and err_sig return to 0; go to IDLE. This cycle lets the owner drop its code, so a stale code is never re-granted.
- func_done_sig outside RUN is ignored.
- The non-owner's request is never dropped. It stays pending and is granted from the next IDLE.
- The done pulse goes only to the owner. req_a_done and req_b_done are never high together.

## Timing
- Request visible in IDLE at cycle t: func_start_sig valid from t+1. Grant latency is 1 cycle.
- func_done_sig sampled high at cycle u: func_start_sig = 00 and owner done = 1 at u+1 (RELEASE); IDLE at u+2. The earliest next func_start_sig is u+3.
- Invalid code seen at t: done and err_sig high at t+1; IDLE at t+2.
- Timeout abort: done and err_sig assert TIMEOUT_CYCLES cycles after func_start_sig first asserts.
- func_done_sig and the timeout condition in the same cycle: done wins, no err_sig.
- rst asserted in any state: at the next edge all outputs are at reset values, even mid-run or during a done pulse. After release, arbitration restarts favouring A.
- Back-to-back alternation under continuous contention: A, B, A, B… with no requester starved.

## Test plan
- A = 2'b10 only, function done 20 cycles after start:
  - func_start_sig = 10 one cycle after request; req_a_done pulses 1 cycle after func_done_sig
  - busy spans the run plus RELEASE; err_sig stays 0
- A = 10 and B = 01 both from reset, each re-requesting immediately after its done:
  - grants go A, B, A, B; owner toggles
  - func_start_sig alternates 10/01 with a 2-cycle idle gap of 00 between runs
- TIMEOUT_CYCLES = 8, B = 01, func_done_sig never asserts:
  - func_start_sig = 01 for exactly 8 cycles, then 00
  - req_b_done and err_sig pulse together; A is grantable after RELEASE
- A = 11:
  - func_start_sig stays 00; req_a_done and err_sig pulse 1 cycle after request; back in IDLE 2 cycles later
- Stray and edge cases:
  - func_done_sig pulsed in IDLE: no outputs change
  - func_done_sig on the same cycle the watchdog expires: done pulses, err_sig = 0
- rst pulsed during a run (func_start_sig = 10):
  - next edge gives func_start_sig = 00, busy = 0, owner = 0, no done pulse
  - with both requesting after release, A is granted first

Source files
------------

// File: rtl/beep_func_arbiter_if.sv
// Bus between the two command controllers, the shared beep function module
// and the round-robin arbiter that owns it.
interface beep_func_arbiter_if;
  logic [1:0] req_a_start;
  logic       req_a_done;
  logic [1:0] req_b_start;
  logic       req_b_done;
  logic [1:0] func_start_sig;
  logic       func_done_sig;
  logic       busy;
  logic       owner;
  logic       err_sig;

  // Requesters and function module side.
  modport master (
    output req_a_start, req_b_start, func_done_sig,
    input  req_a_done, req_b_done, func_start_sig, busy, owner, err_sig
  );

  // Arbiter side.
  modport slave (
    input  req_a_start, req_b_start, func_done_sig,
    output req_a_done, req_b_done, func_start_sig, busy, owner, err_sig
  );
endinterface

// File: rtl/beep_func_arbiter.sv
// Round-robin arbiter sharing one beep function module between two command
// controllers, with done routing back to the owner and a run watchdog.
module beep_func_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
  parameter int unsigned TO_W           = 24
) (
  input logic                clk,
  input logic                rst,
  beep_func_arbiter_if.slave bus
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [1:0]      CODE_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ptr, w_ptr_nxt;
  logic            r_owner, w_owner_nxt;
  logic [1:0]      r_cmd, w_cmd_nxt;
  logic [1:0]      r_func_start, w_func_start_nxt;
  logic            r_done_a, w_done_a_nxt;
  logic            r_done_b, w_done_b_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, w_busy_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;

  logic            w_pend_a, w_pend_b, w_win;
  logic [1:0]      w_code;

  // Winner: 1 = B. r_ptr = 1 means B is favoured on contention.
  assign w_pend_a = |bus.req_a_start;
  assign w_pend_b = |bus.req_b_start;
  assign w_win    = w_pend_b & (~w_pend_a | r_ptr);
  assign w_code   = w_win ? bus.req_b_start : bus.req_a_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      r_cmd        <= 2'b00;
      r_func_start <= 2'b00;
      r_done_a     <= 1'b0;
      r_done_b     <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_cmd        <= w_cmd_nxt;
      r_func_start <= w_func_start_nxt;
      r_done_a     <= w_done_a_nxt;
      r_done_b     <= w_done_b_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_owner_nxt      = r_owner;
    w_cmd_nxt        = r_cmd;
    w_cnt_nxt        = r_cnt;
    w_func_start_nxt = 2'b00;
    w_done_a_nxt     = 1'b0;
    w_done_b_nxt     = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pend_a | w_pend_b) begin
          w_owner_nxt = w_win;
          w_ptr_nxt   = ~w_win;
          w_cmd_nxt   = w_code;
          // An invalid code is rejected without touching the function module.
          if (w_code == CODE_BAD) begin
            w_done_a_nxt = ~w_win;
            w_done_b_nxt = w_win;
            w_err_nxt    = 1'b1;
            w_state_nxt  = ST_RELEASE;
          end else begin
            w_func_start_nxt = w_code;
            w_cnt_nxt        = '0;
            w_state_nxt      = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.func_done_sig) begin
          w_done_a_nxt = ~r_owner;
          w_done_b_nxt = r_owner;
          w_state_nxt  = ST_RELEASE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_done_a_nxt = ~r_owner;
          w_done_b_nxt = r_owner;
          w_err_nxt    = 1'b1;
          w_state_nxt  = ST_RELEASE;
        end else begin
          w_func_start_nxt = r_cmd;
          w_cnt_nxt        = r_cnt + TO_W'(1);
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign bus.req_a_done     = r_done_a;
  assign bus.req_b_done     = r_done_b;
  assign bus.func_start_sig = r_func_start;
  assign bus.busy           = r_busy;
  assign bus.owner          = r_owner;
  assign bus.err_sig        = r_err;

endmodule

// File: tb/tb_beep_func_arbiter.sv
// Randomized scoreboard bench for beep_func_arbiter: a transaction-level model
// predicts each grant, a monitor checks every done pulse against it.
module tb_beep_func_arbiter;

  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  beep_func_arbiter_if bus();

  beep_func_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       owner;
    logic [1:0] code;
    logic       err;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rnd_code();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 4) return 2'b10;
    if (r < 8) return 2'b01;
    if (r == 8) return 2'b11;
    return 2'b00;
  endfunction

  // Monitor: per-cycle invariants plus one scoreboard pop per done pulse.
  task automatic monitor();
    int         run_len = 0;
    int         gap = 0;
    bit         have_prev = 1'b0;
    logic [1:0] run_code = 2'b00;
    logic [1:0] fs;
    logic       da, db, er, bz, ow;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        fs = bus.func_start_sig;
        da = bus.req_a_done;
        db = bus.req_b_done;
        er = bus.err_sig;
        bz = bus.busy;
        ow = bus.owner;
        chk("busy", 32'(bz), 32'((fs != 2'b00) || da || db));
        chk("done_excl", 32'(da & db), 32'd0);
        if (da || db) begin
          chk("fs_at_done", 32'(fs), 32'd0);
          if (run_len == 0 && have_prev) chk("gap", 32'(gap), 32'd2);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("owner", 32'(ow), 32'(e.owner));
            chk("done_line", 32'({da, db}), 32'(e.owner ? 2'b01 : 2'b10));
            chk("err", 32'(er), 32'(e.err));
            chk("run_len", 32'(run_len), 32'(e.len));
            chk("code", 32'(run_code), 32'((e.code == 2'b11) ? 2'b00 : e.code));
          end
          run_len   = 0;
          run_code  = 2'b00;
          gap       = 1;
          have_prev = 1'b1;
        end else begin
          chk("err_alone", 32'(er), 32'd0);
          if (fs != 2'b00) begin
            if (run_len == 0) begin
              if (have_prev) chk("gap", 32'(gap), 32'd2);
              run_code = fs;
            end else begin
              chk("code_hold", 32'(fs), 32'(run_code));
            end
            run_len++;
          end else if (have_prev) begin
            gap++;
          end
        end
      end
    end
  endtask

  // Function module model: pulse done k cycles after start (k < 0: never).
  task automatic run_txn(input int k, output bit ga, output bit gb);
    bit started = 1'b0;
    bit got = 1'b0;
    int j = 0;
    ga = 1'b0;
    gb = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (bus.req_a_done || bus.req_b_done) begin
        got = 1'b1;
        ga  = bus.req_a_done;
        gb  = bus.req_b_done;
      end else begin
        if (!started && bus.func_start_sig != 2'b00) started = 1'b1;
        if (started) begin
          bus.func_done_sig = (j == k);
          j++;
        end
      end
    end
    bus.func_done_sig = 1'b0;
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  task automatic rst_mid(input logic [1:0] ca, input logic [1:0] cb);
    bit seen = 1'b0;
    bus.req_a_start = ca;
    bus.req_b_start = cb;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = (bus.func_start_sig != 2'b00);
    end
    chk("rst_pre_run", 32'(bus.func_start_sig), 32'(ca | cb));
    chk("rst_pre_owner", 32'(bus.owner), 32'(cb != 2'b00));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_fs", 32'(bus.func_start_sig), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_owner", 32'(bus.owner), 32'd0);
    chk("rst_done", 32'({bus.req_a_done, bus.req_b_done}), 32'd0);
    chk("rst_err", 32'(bus.err_sig), 32'd0);
    rst = 1'b0;
    bus.req_a_start = 2'b10;
    bus.req_b_start = 2'b01;
    @(negedge clk);
    chk("post_rst_fs", 32'(bus.func_start_sig), 32'(2'b10));
    chk("post_rst_owner", 32'(bus.owner), 32'd0);
    bus.func_done_sig = 1'b1;
    @(negedge clk);
    bus.func_done_sig = 1'b0;
    chk("post_rst_done", 32'({bus.req_a_done, bus.req_b_done}), 32'(2'b10));
    bus.req_a_start = 2'b00;
    bus.req_b_start = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [1:0] a_code, b_code, code;
    bit         m_ptr, win, last_win, pa, pb, ga, gb;
    int         k;
    int unsigned r;
    exp_t       e;

    rst = 1'b1;
    bus.req_a_start   = 2'b00;
    bus.req_b_start   = 2'b00;
    bus.func_done_sig = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("reset_fs", 32'(bus.func_start_sig), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_owner", 32'(bus.owner), 32'd0);
    chk("reset_done", 32'({bus.req_a_done, bus.req_b_done}), 32'd0);
    chk("reset_err", 32'(bus.err_sig), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Both request from reset; first 8 grants keep re-requesting to show alternation.
    a_code   = 2'b10;
    b_code   = 2'b01;
    m_ptr    = 1'b0;
    last_win = 1'b0;
    for (int n = 0; n < 60; n++) begin
      bus.req_a_start = a_code;
      bus.req_b_start = b_code;
      pa   = (a_code != 2'b00);
      pb   = (b_code != 2'b00);
      win  = pb && (!pa || m_ptr);
      m_ptr = !win;
      code = win ? b_code : a_code;
      r = $urandom_range(0, 9);
      if (code == 2'b11)  k = 0;
      else if (r < 2)     k = -1;
      else if (r == 2)    k = int'(TO) - 1;
      else                k = int'($urandom_range(0, TO - 2));
      e.owner = win;
      e.code  = code;
      e.err   = (code == 2'b11) || (k < 0);
      e.len   = (code == 2'b11) ? 0 : ((k < 0) ? int'(TO) : k + 1);
      exp_q.push_back(e);
      last_win = win;
      run_txn(k, ga, gb);
      if (ga && n >= 8) a_code = rnd_code();
      if (gb && n >= 8) b_code = rnd_code();
      if (a_code == 2'b00 && b_code == 2'b00) begin
        if ($urandom_range(0, 1) == 1) a_code = 2'b10;
        else                           b_code = 2'b01;
      end
    end
    bus.req_a_start = 2'b00;
    bus.req_b_start = 2'b00;
    repeat (2) @(negedge clk);
    chk("q_drain", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Stray done while idle must leave every output unchanged.
    repeat (2) @(negedge clk);
    bus.func_done_sig = 1'b1;
    @(negedge clk);
    bus.func_done_sig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stray_fs", 32'(bus.func_start_sig), 32'd0);
      chk("stray_busy", 32'(bus.busy), 32'd0);
      chk("stray_done", 32'({bus.req_a_done, bus.req_b_done}), 32'd0);
      chk("stray_err", 32'(bus.err_sig), 32'd0);
      chk("stray_owner", 32'(bus.owner), 32'(last_win));
      @(negedge clk);
    end

    rst_mid(2'b10, 2'b00);
    rst_mid(2'b00, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "global timeout");
  end

endmodule
